// File: rtl/nora_mem_pkg.sv
// rtl/nora_mem_pkg.sv - state encoding and timing-parameter bounds for the SRAM bus initiator
package nora_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_GNT,
    S_SETUP,
    S_RD_STROBE,
    S_WR_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  // A timing value must be loadable into the down-counter and must not be zero.
  function automatic bit timing_ok(input int value, input int cnt_w);
    return (value >= 1) && (value <= (1 << cnt_w) - 1);
  endfunction

endpackage

// File: rtl/sram_bus_initiator.sv
// rtl/sram_bus_initiator.sv - single-cycle SRAM read/write initiator with programmable strobe timing
module sram_bus_initiator
  import nora_mem_pkg::*;
#(
  parameter int ADDR_SETUP = 1,
  parameter int RD_CYCLES  = 3,
  parameter int WR_CYCLES  = 2,
  parameter int DATA_HOLD  = 1,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_i,
  input  logic        rw_i,
  input  logic [20:0] addr_i,
  input  logic [7:0]  wdata_i,
  output logic        ack_o,
  output logic [7:0]  rdata_o,
  output logic        busy_o,
  input  logic        bus_grant,
  output logic [20:0] mem_addr_o,
  output logic        mem_addr_oe,
  output logic [7:0]  mdata_o,
  output logic        mdata_oe,
  input  logic [7:0]  mdata_i,
  output logic        m1csn_o,
  output logic        mrdn_o,
  output logic        mwrn_o
);

  if (!timing_ok(ADDR_SETUP, CNT_W) || !timing_ok(RD_CYCLES, CNT_W) ||
      !timing_ok(WR_CYCLES, CNT_W) || !timing_ok(DATA_HOLD, CNT_W)) begin : g_bad_timing
    $error("sram_bus_initiator: timing parameter is zero or exceeds the counter width");
  end

  localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(ADDR_SETUP);
  localparam logic [CNT_W-1:0] L_RD    = CNT_W'(RD_CYCLES);
  localparam logic [CNT_W-1:0] L_WR    = CNT_W'(WR_CYCLES);
  localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(DATA_HOLD);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rw;
  logic [20:0]       r_addr;
  logic [7:0]        r_wdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      ack_o       <= 1'b0;
      busy_o      <= 1'b0;
      rdata_o     <= '0;
      mem_addr_o  <= '0;
      mem_addr_oe <= 1'b0;
      mdata_o     <= '0;
      mdata_oe    <= 1'b0;
      m1csn_o     <= 1'b1;
      mrdn_o      <= 1'b1;
      mwrn_o      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            r_rw    <= rw_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            busy_o  <= 1'b1;
            r_state <= S_WAIT_GNT;
          end
        end
        S_WAIT_GNT: begin
          if (bus_grant) begin
            mem_addr_o  <= r_addr;
            mem_addr_oe <= 1'b1;
            m1csn_o     <= 1'b0;
            if (!r_rw) begin
              mdata_o  <= r_wdata;
              mdata_oe <= 1'b1;
            end
            r_cnt   <= L_SETUP;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == L_ONE) begin
            if (r_rw) begin
              mrdn_o  <= 1'b0;
              r_cnt   <= L_RD;
              r_state <= S_RD_STROBE;
            end else begin
              mwrn_o  <= 1'b0;
              r_cnt   <= L_WR;
              r_state <= S_WR_STROBE;
            end
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        S_RD_STROBE: begin
          // Data is captured on the last strobe cycle, together with strobe release.
          if (r_cnt == L_ONE) begin
            rdata_o     <= mdata_i;
            mrdn_o      <= 1'b1;
            m1csn_o     <= 1'b1;
            mem_addr_oe <= 1'b0;
            ack_o       <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        S_WR_STROBE: begin
          if (r_cnt == L_ONE) begin
            mwrn_o  <= 1'b1;
            r_cnt   <= L_HOLD;
            r_state <= S_HOLD;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        S_HOLD: begin
          if (r_cnt == L_ONE) begin
            mdata_oe    <= 1'b0;
            mem_addr_oe <= 1'b0;
            m1csn_o     <= 1'b1;
            ack_o       <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        S_DONE: begin
          ack_o   <= 1'b0;
          busy_o  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_initiator.sv
// tb/tb_sram_bus_initiator.sv - bench for sram_bus_initiator (default timing and all-minimum timing)
module tb_sram_bus_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, req, rw, bus_grant;
  logic [20:0] addr;
  logic [7:0]  wdata;

  logic        ack_a, busy_a, maddr_oe_a, mdata_oe_a, m1csn_a, mrdn_a, mwrn_a;
  logic [7:0]  rdata_a, mdata_o_a, mdata_i_a;
  logic [20:0] maddr_a;
  logic        ack_b, busy_b, maddr_oe_b, mdata_oe_b, m1csn_b, mrdn_b, mwrn_b;
  logic [7:0]  rdata_b, mdata_o_b, mdata_i_b;
  logic [20:0] maddr_b;

  sram_bus_initiator u_dut_a (
    .clk(clk), .resetn(resetn), .req_i(req), .rw_i(rw), .addr_i(addr), .wdata_i(wdata),
    .ack_o(ack_a), .rdata_o(rdata_a), .busy_o(busy_a), .bus_grant(bus_grant),
    .mem_addr_o(maddr_a), .mem_addr_oe(maddr_oe_a), .mdata_o(mdata_o_a), .mdata_oe(mdata_oe_a),
    .mdata_i(mdata_i_a), .m1csn_o(m1csn_a), .mrdn_o(mrdn_a), .mwrn_o(mwrn_a)
  );

  sram_bus_initiator #(.ADDR_SETUP(1), .RD_CYCLES(1), .WR_CYCLES(1), .DATA_HOLD(1)) u_dut_b (
    .clk(clk), .resetn(resetn), .req_i(req), .rw_i(rw), .addr_i(addr), .wdata_i(wdata),
    .ack_o(ack_b), .rdata_o(rdata_b), .busy_o(busy_b), .bus_grant(bus_grant),
    .mem_addr_o(maddr_b), .mem_addr_oe(maddr_oe_b), .mdata_o(mdata_o_b), .mdata_oe(mdata_oe_b),
    .mdata_i(mdata_i_b), .m1csn_o(m1csn_b), .mrdn_o(mrdn_b), .mwrn_o(mwrn_b)
  );

  // SRAM models: A has a 20-unit access time, B answers immediately.
  logic [7:0] mem_a [int];
  logic [7:0] mem_b [int];
  logic [7:0] ref_mem [int];
  logic [7:0] last_commit_a;

  always @(mrdn_a or m1csn_a or maddr_a)
    mdata_i_a <= #20 (!mrdn_a && !m1csn_a && mem_a.exists(int'(maddr_a))) ? mem_a[int'(maddr_a)] : 8'hEE;
  always @(posedge mwrn_a)
    if (!m1csn_a && mdata_oe_a) begin
      mem_a[int'(maddr_a)] = mdata_o_a;
      last_commit_a = mdata_o_a;
    end
  always @(mrdn_b or m1csn_b or maddr_b)
    mdata_i_b = (!mrdn_b && !m1csn_b && mem_b.exists(int'(maddr_b))) ? mem_b[int'(maddr_b)] : 8'hEE;
  always @(posedge mwrn_b)
    if (!m1csn_b && mdata_oe_b) mem_b[int'(maddr_b)] = mdata_o_b;

  // Pin-protocol monitor and strobe-width measurement.
  int viol = 0, rd_run_a = 0, wr_run_a = 0, rd_w_a = 0, wr_w_a = 0;
  int rd_run_b = 0, wr_run_b = 0, b_bad_width = 0, b_pulses = 0, ack_cnt_a = 0;
  always @(negedge clk) begin
    if (!mrdn_a && !mwrn_a) viol++;
    if ((!mrdn_a || !mwrn_a) && (m1csn_a || !maddr_oe_a)) viol++;
    if (!mrdn_b && !mwrn_b) viol++;
    if ((!mrdn_b || !mwrn_b) && (m1csn_b || !maddr_oe_b)) viol++;
    if (!mrdn_a) rd_run_a++; else if (rd_run_a != 0) begin rd_w_a = rd_run_a; rd_run_a = 0; end
    if (!mwrn_a) wr_run_a++; else if (wr_run_a != 0) begin wr_w_a = wr_run_a; wr_run_a = 0; end
    if (!mrdn_b) rd_run_b++;
    else if (rd_run_b != 0) begin if (rd_run_b != 1) b_bad_width++; b_pulses++; rd_run_b = 0; end
    if (!mwrn_b) wr_run_b++;
    else if (wr_run_b != 0) begin if (wr_run_b != 1) b_bad_width++; b_pulses++; wr_run_b = 0; end
    if (ack_a) ack_cnt_a++;
  end

  int n_pass = 0, n_fail = 0, n_chk = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One access through both DUTs; grant is held low for g_low negedges after acceptance.
  task automatic access(input logic w_rw, input logic [20:0] a, input logic [7:0] d,
                        input int g_low, input string tag);
    int lat_a, lat_b, exp_a, exp_b;
    bit b_done, got, md_ok, stall_ok;
    logic [7:0] exp_d;
    if (!w_rw) ref_mem[int'(a)] = d;
    exp_d = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
    @(negedge clk);
    req = 1'b1; rw = w_rw; addr = a; wdata = d;
    if (g_low > 0) bus_grant = 1'b0;
    @(negedge clk);
    req = 1'b0; rw = 1'($urandom); addr = 21'($urandom); wdata = 8'($urandom);
    lat_a = 0; lat_b = 0; b_done = 0; got = 0; md_ok = 1; stall_ok = 1;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) @(negedge clk);
      lat_a++;
      if (!b_done) lat_b++;
      if (ack_b) b_done = 1;
      if (i < g_low) begin
        if ({busy_a, busy_b, m1csn_a, mrdn_a, mwrn_a, maddr_oe_a, mdata_oe_a} !== 7'b1111100) stall_ok = 0;
        if ({m1csn_b, mrdn_b, mwrn_b, maddr_oe_b, mdata_oe_b} !== 5'b11100) stall_ok = 0;
        if (i == g_low - 1) bus_grant = 1'b1;
      end
      if (!w_rw && !m1csn_a && (mdata_oe_a !== 1'b1 || mdata_o_a !== d || maddr_a !== a)) md_ok = 0;
      if (ack_a) begin got = 1; break; end
    end
    exp_a = 6 + ((g_low > 0) ? g_low - 1 : 0);
    exp_b = (w_rw ? 4 : 5) + ((g_low > 0) ? g_low - 1 : 0);
    check({tag, "_ack_seen"}, 32'(got), 32'd1);
    check({tag, "_latency_a"}, 32'(lat_a), 32'(exp_a));
    check({tag, "_latency_b"}, 32'(lat_b), 32'(exp_b));
    if (g_low > 0) check({tag, "_stalled_inactive"}, 32'(stall_ok), 32'd1);
    if (w_rw) check({tag, "_rdata_at_ack"}, 32'(rdata_a), 32'(exp_d));
    @(negedge clk);
    check({tag, "_ack_pulse_busy_after"}, {30'd0, ack_a, busy_a}, 32'd0);
    if (w_rw) begin
      check({tag, "_rdata_held"}, 32'(rdata_a), 32'(exp_d));
      check({tag, "_rdata_b"}, 32'(rdata_b), 32'(exp_d));
      check({tag, "_mrdn_width"}, 32'(rd_w_a), 32'd3);
    end else begin
      check({tag, "_md_addr_stable"}, 32'(md_ok), 32'd1);
      check({tag, "_md_at_mwrn_rise"}, 32'(last_commit_a), 32'(d));
      check({tag, "_mwrn_width"}, 32'(wr_w_a), 32'd2);
    end
  endtask

  logic [20:0] pool [8];
  int ack_snap;
  bit seen;

  initial begin
    resetn = 1'b0; req = 1'b0; rw = 1'b0; addr = '0; wdata = '0; bus_grant = 1'b1;
    pool = '{21'h000000, 21'h1FFFFF, 21'h00100, 21'h00101, 21'h0AAAA, 21'h15555, 21'h1ABCE, 21'h00200};
    #12;
    check("rst_ctrl_a", {25'd0, ack_a, busy_a, maddr_oe_a, mdata_oe_a, m1csn_a, mrdn_a, mwrn_a}, 32'h7);
    check("rst_ctrl_b", {25'd0, ack_b, busy_b, maddr_oe_b, mdata_oe_b, m1csn_b, mrdn_b, mwrn_b}, 32'h7);
    check("rst_rdata", 32'(rdata_a), 32'd0);
    check("rst_addr", 32'(maddr_a), 32'd0);
    @(negedge clk); resetn = 1'b1;

    access(1'b0, 21'h1ABCD, 8'h5A, 0, "wr_1abcd");
    access(1'b1, 21'h1ABCD, 8'h00, 0, "rd_1abcd");
    access(1'b0, 21'h0BEEF, 8'hA7, 0, "wr_beef");
    access(1'b1, 21'h0BEEF, 8'h00, 10, "rd_grant_late");

    // Back-to-back writes with req held: one IDLE cycle after each ack.
    @(negedge clk);
    req = 1'b1; rw = 1'b0; addr = 21'h00010; wdata = 8'h11;
    for (int k = 0; k < 3; k++) begin
      ref_mem[32'h10 + k] = 8'h11 * 8'(k + 1);
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        if (ack_a) seen = 1;
      end
      check("b2b_ack_seen", 32'(seen), 32'd1);
      if (k < 2) begin addr = 21'h00011 + 21'(k); wdata = 8'h11 * 8'(k + 2); end
      else req = 1'b0;
      @(negedge clk);
      check("b2b_idle_gap", 32'(busy_a), 32'd0);
      if (k < 2) begin
        @(negedge clk);
        check("b2b_accept_after_gap", 32'(busy_a), 32'd1);
      end
    end
    repeat (8) @(negedge clk);
    for (int k = 0; k < 3; k++) access(1'b1, 21'h00010 + 21'(k), 8'h00, 0, "b2b_readback");

    // Reset in the middle of a write strobe.
    @(negedge clk);
    req = 1'b1; rw = 1'b0; addr = 21'h1F000; wdata = 8'hC3;
    @(negedge clk);
    req = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (mwrn_a === 1'b0) seen = 1; else @(negedge clk);
    end
    check("rst_mid_reached_wr_strobe", 32'(seen), 32'd1);
    ack_snap = ack_cnt_a;
    #2 resetn = 1'b0;
    #1;
    check("rst_mid_release_a", {26'd0, mwrn_a, m1csn_a, mrdn_a, mdata_oe_a, busy_a, ack_a}, 32'h38);
    check("rst_mid_release_b", {26'd0, mwrn_b, m1csn_b, mrdn_b, mdata_oe_b, busy_b, ack_b}, 32'h38);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_mid_no_ack", 32'(ack_cnt_a), 32'(ack_snap));
    check("rst_mid_idle", {30'd0, busy_a, busy_b}, 32'd0);

    for (int n = 0; n < 16; n++) begin
      logic [20:0] ra;
      logic        rrw;
      ra  = pool[$urandom_range(0, 7)];
      rrw = 1'($urandom);
      if (!ref_mem.exists(int'(ra))) rrw = 1'b0;
      access(rrw, ra, 8'($urandom), (n % 5 == 4) ? 1 + int'($urandom_range(0, 3)) : 0,
             rrw ? "rand_rd" : "rand_wr");
    end

    check("strobe_rules_violations", 32'(viol), 32'd0);
    check("min_timing_width_errors", 32'(b_bad_width), 32'd0);
    check("min_timing_pulses_seen", 32'(b_pulses > 0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_bus_initiator.md
Name: sram_bus_initiator

Overview:
- Memory-bus initiator inside NORA. It runs single SRAM read and write cycles on MAH/MAL/MD/M1CSn/MRDn/MWRn on behalf of an internal requester, such as the ICD debug port or the boot loader, while the 65C02 is parked.
- It drives the SRAM pins directly with programmable strobe timing, so the external SRAM sees exactly the pin protocol it sees during CPU-driven cycles.
- A top-level mux gives this block the memory pins only while `bus_grant` is high.

Parameters:
- ADDR_SETUP, 1, clk cycles the address is stable before any strobe falls (min 1)
- RD_CYCLES, 3, clk cycles MRDn is held low; MD is sampled on the last one (min 1)
- WR_CYCLES, 2, clk cycles MWRn is held low (min 1)
- DATA_HOLD, 1, clk cycles MD and address are held after MWRn rises (min 1)
- CNT_W, 4, width of the timing counter; every timing parameter must be <= 2**CNT_W-1

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req_i  in  1  access request; level, sampled in IDLE
- rw_i  in  1  1 = read, 0 = write; sampled with req_i
- addr_i  in  21  SRAM byte address
- wdata_i  in  8  write data
- ack_o  out  1  one-cycle completion pulse
- rdata_o  out  8  read data; valid when ack_o is high, then held until the next read completes
- busy_o  out  1  high from request acceptance until ack_o; keeps the CPU parked
- bus_grant  in  1  memory pins are owned by this block (CPU parked, CBE low)
- mem_addr_o  out  21  drives MAH[20:12] and MAL[11:0]
- mem_addr_oe  out  1  enable for the MAL drivers
- mdata_o  out  8  MD output data
- mdata_oe  out  1  MD output enable
- mdata_i  in  8  MD input
- m1csn_o  out  1  SRAM chip select, active low
- mrdn_o  out  1  read strobe, active low
- mwrn_o  out  1  write strobe, active low

Behaviour:
- Reset (asynchronous):
  - Outputs: ack_o=0, busy_o=0, rdata_o=00, mem_addr_o=0, mem_addr_oe=0, mdata_oe=0, m1csn_o=1, mrdn_o=1, mwrn_o=1.
  - State goes to IDLE.
  - Reset during an access releases all strobes immediately; no ack is issued.
- All strobe and enable outputs are registered and glitch-free.
- FSM states: IDLE, WAIT_GNT, SETUP, RD_STROBE, WR_STROBE, HOLD, DONE.
  - IDLE: on req_i=1, latch rw_i, addr_i and wdata_i, set busy_o=1, go to WAIT_GNT.
  - WAIT_GNT: wait for bus_grant=1, with no timeout. Then drive mem_addr_o, set mem_addr_oe=1 and m1csn_o=0. For a write, also set mdata_oe=1 with the latched wdata. Load the counter with ADDR_SETUP and go to SETUP.
  - SETUP: count down to 1. Then go to RD_STROBE (mrdn_o=0, counter=RD_CYCLES) or WR_STROBE (mwrn_o=0, counter=WR_CYCLES).
  - RD_STROBE: on the cycle the counter reaches 1, register mdata_i into rdata_o and set mrdn_o=1, m1csn_o=1, mem_addr_oe=0. Go to DONE.
  - WR_STROBE: when the counter reaches 1, set mwrn_o=1 (rising edge commits the write) and load DATA_HOLD. Go to HOLD.
  - HOLD: keep address, MD and CS stable until the counter reaches 1. Then release mdata_oe, mem_addr_oe and m1csn_o together. Go to DONE.
  - DONE: ack_o=1 for exactly one cycle, busy_o=0, return to IDLE.
- A new req_i is never accepted in DONE, so back-to-back requests have a minimum of one IDLE cycle between ack and the next acceptance.
- mrdn_o and mwrn_o are never low in the same cycle.
- The strobes are never low while m1csn_o=1 or mem_addr_oe=0.
- bus_grant falling after SETUP has been entered is a protocol violation by the arbiter. The block ignores it and finishes the cycle. busy_o stays high for the arbiter to observe.
- req_i and the data inputs may change after acceptance with no effect on the cycle in progress.
- Address bits are passed straight through with no bank translation; 21 bits cover 2 MB.
- Latency from acceptance to ack, with grant already high:
  - read: 1 + ADDR_SETUP + RD_CYCLES + 1 cycles
  - write: 1 + ADDR_SETUP + WR_CYCLES + DATA_HOLD + 1 cycles
  - defaults: 6 cycles for both.

Decomposition:
- nora_mem_pkg: FSM state encoding and a timing-parameter bounds check (elaboration error if any parameter is 0 or exceeds the counter width).
- No sub-module. The FSM and the shared down-counter live in one module.

Test Plan:
- Write A=0x1ABCD, D=0x5A with grant high:
  - Check the MWRn pulse is 2 clk long and MD is stable from SETUP through HOLD.
  - Check MD is stable at the MWRn rising edge.
  - Check ack arrives 6 cycles after acceptance.
- Read back 0x1ABCD from the behavioural SRAM model (20 ns access time):
  - rdata_o=0x5A when ack_o=1, and rdata_o holds 0x5A afterwards.
  - MRDn is low for exactly 3 clk.
- Request with bus_grant=0 for 10 cycles:
  - busy_o=1 and all strobes stay inactive.
  - Once grant rises, the cycle completes normally.
- Writes 0x11/0x22/0x33 to 0x00010..0x00012, then reads back:
  - Data matches.
  - Exactly one IDLE cycle between each ack and the next acceptance.
- Assert resetn while in WR_STROBE:
  - mwrn_o, m1csn_o, mrdn_o and mdata_oe go inactive within the same delta.
  - No ack; state returns to IDLE after release.
- Run all cycles with RD_CYCLES=1, WR_CYCLES=1, DATA_HOLD=1, ADDR_SETUP=1:
  - Minimum-width strobes are still 1 clk.
  - The never-both-low and never-while-deselected strobe rules hold on every cycle.
